// File: rtl/shift_exec_unit.sv
// Multi-cycle SLL/SRL/SRA unit: resolves one shift-amount bit per cycle (logarithmic),
// with valid/ready handshakes toward issue and writeback.
module shift_exec_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [SHW-1:0]  shamt,
  input  logic [4:0]      rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      out_rd,
  output logic            busy
);

  localparam int STEP_W = $clog2(SHW);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SHW - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state;
  logic [STEP_W-1:0] step;
  logic [XLEN-1:0]   wreg;
  logic [1:0]        op_q;
  logic [SHW-1:0]    shamt_q;
  logic [4:0]        rd_q;
  logic              sign_q;

  // One logarithmic stage: shift by 2^k, filling with zeros or the captured sign.
  function automatic logic [XLEN-1:0] shift_step(input logic [XLEN-1:0] w,
                                                 input logic [1:0]      o,
                                                 input logic            s,
                                                 input logic [STEP_W-1:0] k);
    logic [SHW-1:0]  amt;
    logic [XLEN-1:0] fill;
    amt  = SHW'(1) << k;
    fill = s ? ~({XLEN{1'b1}} >> amt) : '0;
    case (o)
      2'b00:   return w << amt;
      2'b01:   return w >> amt;
      2'b10:   return (w >> amt) | fill;
      default: return w;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      step    <= '0;
      wreg    <= '0;
      op_q    <= '0;
      shamt_q <= '0;
      rd_q    <= '0;
      sign_q  <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            wreg    <= a;
            op_q    <= op;
            shamt_q <= shamt;
            rd_q    <= rd;
            sign_q  <= a[XLEN-1];
            step    <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (shamt_q[step]) wreg <= shift_step(wreg, op_q, sign_q, step);
          if (step == LAST_STEP) state <= DONE;
          else                   step  <= step + STEP_W'(1);
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign result    = wreg;
  assign out_rd    = rd_q;

endmodule

// File: tb/tb_shift_exec_unit.sv
// Directed bench for shift_exec_unit: shift kinds, latency, backpressure, flush and async reset.
module tb_shift_exec_unit;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0]  op;
  logic [31:0] a, result;
  logic [4:0]  shamt, rd, out_rd;

  int n_checks = 0;
  int n_fail   = 0;

  shift_exec_unit #(.XLEN(32), .SHW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .shamt(shamt), .rd(rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_rd(out_rd), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one request on a negedge; it is accepted on the following posedge.
  task automatic issue(input logic [1:0] o, input logic [31:0] av,
                       input logic [4:0] sh, input logic [4:0] r);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = av; shamt = sh; rd = r;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = 32'h1234_5678; shamt = 5'd9; op = 2'b00; rd = 5'd0;
  endtask

  // Count edges after accept until out_valid; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
      if (lat >= 20) begin lat = -1; break; end
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [4:0] sh,
                        input logic [4:0] r, output logic [31:0] res,
                        output logic [4:0] ord, output int lat);
    issue(o, av, sh, r);
    wait_valid(lat);
    res = result;
    ord = out_rd;
    handshake();
  endtask

  task automatic test_reset();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 00000000", result); end
    n_checks++; if (out_rd !== 5'd0) begin n_fail++; $display("FAIL reset_out_rd got %0d want 0", out_rd); end
  endtask

  task automatic test_sll();
    logic [31:0] res; logic [4:0] ord; int lat;
    run_op(2'b00, 32'h0000_0001, 5'd31, 5'd7, res, ord, lat);
    n_checks++; if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL sll_result got %h want 80000000", res); end
    n_checks++; if (ord !== 5'd7) begin n_fail++; $display("FAIL sll_out_rd got %0d want 7", ord); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL sll_latency got %0d want 5", lat); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sll_in_ready_after got %0b want 1", in_ready); end
  endtask

  task automatic test_right_shifts();
    logic [31:0] res; logic [4:0] ord; int lat;
    run_op(2'b01, 32'h8000_0000, 5'd4, 5'd1, res, ord, lat);
    n_checks++; if (res !== 32'h0800_0000) begin n_fail++; $display("FAIL srl_result got %h want 08000000", res); end
    run_op(2'b10, 32'h8000_0000, 5'd4, 5'd2, res, ord, lat);
    n_checks++; if (res !== 32'hF800_0000) begin n_fail++; $display("FAIL sra_neg_result got %h want f8000000", res); end
    n_checks++; if (ord !== 5'd2) begin n_fail++; $display("FAIL sra_out_rd got %0d want 2", ord); end
    run_op(2'b10, 32'h7FFF_FFF0, 5'd4, 5'd3, res, ord, lat);
    n_checks++; if (res !== 32'h07FF_FFFF) begin n_fail++; $display("FAIL sra_pos_result got %h want 07ffffff", res); end
    run_op(2'b10, 32'h8000_0000, 5'd31, 5'd4, res, ord, lat);
    n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sra_31_result got %h want ffffffff", res); end
  endtask

  task automatic test_zero_and_reserved();
    logic [31:0] res; logic [4:0] ord; int lat;
    run_op(2'b00, 32'hDEAD_BEEF, 5'd0, 5'd5, res, ord, lat);
    n_checks++; if (res !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL zero_shift_result got %h want deadbeef", res); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL zero_shift_latency got %0d want 5", lat); end
    run_op(2'b11, 32'hDEAD_BEEF, 5'd13, 5'd6, res, ord, lat);
    n_checks++; if (res !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL reserved_result got %h want deadbeef", res); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL reserved_latency got %0d want 5", lat); end
  endtask

  task automatic test_backpressure();
    int lat;
    issue(2'b10, 32'h8000_0010, 5'd4, 5'd12);
    wait_valid(lat);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL bp_latency got %0d want 5", lat); end
    for (int i = 0; i < 3; i++) begin
      in_valid = i[0]; a = 32'hA5A5_0000 + i; shamt = 5'(i + 1);
      @(posedge clk);
      #1;
      n_checks++; if (result !== 32'hF800_0001) begin n_fail++; $display("FAIL bp_result_%0d got %h want f8000001", i, result); end
      n_checks++; if (out_rd !== 5'd12) begin n_fail++; $display("FAIL bp_out_rd_%0d got %0d want 12", i, out_rd); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid_%0d got %0b want 1", i, out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_%0d got %0b want 0", i, in_ready); end
    end
    in_valid = 1'b0;
    handshake();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_after got %0b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_out_valid_after got %0b want 0", out_valid); end
  endtask

  task automatic test_flush();
    logic [31:0] res; logic [4:0] ord; int lat; bit saw;
    issue(2'b00, 32'h0000_00FF, 5'd1, 5'd3);
    repeat (2) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; op = 2'b01; a = 32'hFFFF_0000; shamt = 5'd8; rd = 5'd20;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle_in_ready got %0b want 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %0b want 0", busy); end
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) saw = 1'b1;
    end
    n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL flush_no_result got activity=%0b want 0", saw); end
    run_op(2'b00, 32'h0000_0003, 5'd2, 5'd11, res, ord, lat);
    n_checks++; if (res !== 32'h0000_000C) begin n_fail++; $display("FAIL flush_next_result got %h want 0000000c", res); end
    n_checks++; if (ord !== 5'd11) begin n_fail++; $display("FAIL flush_next_out_rd got %0d want 11", ord); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; logic [4:0] ord; int lat;
    issue(2'b00, 32'h0000_0001, 5'd3, 5'd8);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_shift_busy got %0b want 0", busy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_shift_in_ready got %0b want 1", in_ready); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL rst_shift_result got %h want 00000000", result); end
    rst = 1'b0;
    issue(2'b01, 32'hF000_0000, 5'd1, 5'd17);
    wait_valid(lat);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL rst_pre_done_latency got %0d want 5", lat); end
    #1;
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_done_out_valid got %0b want 0", out_valid); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL rst_done_result got %h want 00000000", result); end
    n_checks++; if (out_rd !== 5'd0) begin n_fail++; $display("FAIL rst_done_out_rd got %0d want 0", out_rd); end
    rst = 1'b0;
    run_op(2'b01, 32'h0000_00F0, 5'd4, 5'd9, res, ord, lat);
    n_checks++; if (res !== 32'h0000_000F) begin n_fail++; $display("FAIL rst_after_result got %h want 0000000f", res); end
    n_checks++; if (ord !== 5'd9) begin n_fail++; $display("FAIL rst_after_out_rd got %0d want 9", ord); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL rst_after_latency got %0d want 5", lat); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'b00; a = '0; shamt = '0; rd = '0;
    #2;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_sll();
    test_right_shifts();
    test_zero_and_reserved();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_exec_unit.md
# shift_exec_unit

Multi-cycle shift execution unit for the integer pipeline. It accepts SLL/SRL/SRA requests from decode/issue over a valid/ready handshake and resolves the shift amount one bit per cycle as a logarithmic shifter. It returns the result plus the destination-register tag to writeback over a second valid/ready handshake. It complements the single-cycle combinational left shifter; this unit handles all three RV32I shift kinds.

## Interface
- XLEN, 32, operand/result width.
- SHW, 5, shift-amount width; 2^SHW must equal XLEN.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort of any in-flight operation.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept; high only in IDLE.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved (pass-through).
- a  input  XLEN  operand to shift.
- shamt  input  SHW  shift amount; only the low SHW bits are used.
- rd  input  5  destination tag, carried unchanged.
- out_valid  output  1  result present.
- out_ready  input  1  writeback accepts the result.
- result  output  XLEN  shifted value.
- out_rd  output  5  tag of the result.
- busy  output  1  high in SHIFT or DONE.

## Operation
- States: IDLE, SHIFT, DONE. The step counter is 3 bits, range 0..SHW-1.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture a into the working register, plus op, shamt, rd, and sign=a[XLEN-1].
  - Clear step to 0 and go to SHIFT.
- SHIFT, each edge:
  - If shamt[step]=1, shift the working register by 2^step.
  - SLL fills with 0. SRL fills with 0. SRA fills with sign.
  - op=11 leaves the register unchanged.
  - Increment step. At step=SHW-1, go to DONE instead of incrementing.
- DONE:
  - out_valid=1. result=working register, out_rd=captured rd.
  - Hold both stable until out_ready=1, then go to IDLE.
- Arithmetic:
  - Shift amounts ≥ XLEN are impossible by construction.
  - shamt=0 executes all SHW steps with no change.
- flush=1 (synchronous):
  - Forces IDLE and out_valid=0 and discards the operation.
  - Overrides every other transition, including an in_valid or out_ready handshake in the same cycle.
  - A request presented while flush=1 is not accepted. in_ready still reads 1 in IDLE, but capture is suppressed.
- rst=1 (asynchronous):
  - Mid-operation, it aborts immediately with no result produced.
  - Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, result=0, out_rd=0, step=0.
- Inputs a/op/shamt/rd are sampled only on the accept edge. Later changes have no effect.

## Timing
- Accept on edge E0.
- Shift steps are applied on edges E1..E5 (SHW=5).
- out_valid rises after E5: fixed latency of SHW cycles from accept to result, independent of shamt and op.
- Output handshake completes on the edge where out_valid&out_ready. in_ready returns to 1 in the following cycle.
- No back-to-back acceptance. Minimum initiation interval is SHW+2 cycles with out_ready held at 1.
- in_ready and busy are decoded from the state register (registered). There is no combinational path from out_ready to in_ready.

## Test plan
- Basic left shift:
  - Stimulus: SLL, a=0x00000001, shamt=31, rd=7.
  - Required: result=0x80000000, out_rd=7, out_valid exactly 5 cycles after accept.
- Right shifts, logical vs arithmetic:
  - Stimulus: SRL a=0x80000000, shamt=4; then SRA with the same a and shamt.
  - Required: SRL result=0x08000000; SRA result=0xF8000000.
  - Also SRA a=0x7FFFFFF0, shamt=4 → 0x07FFFFFF.
- Zero shift and reserved op:
  - Stimulus: SLL a=0xDEADBEEF, shamt=0; then op=11, shamt=13.
  - Required: both return 0xDEADBEEF with 5-cycle latency.
- Backpressure:
  - Stimulus: hold out_ready=0 for 3 cycles after out_valid, while toggling a/shamt/in_valid.
  - Required: result, out_rd and out_valid stay constant; in_ready stays 0.
  - On the handshake, in_ready=1 the next cycle.
- Flush:
  - Stimulus: assert flush for 1 cycle at step 2, with in_valid=1 in that cycle.
  - Required: no out_valid, not accepted, state IDLE next cycle.
  - A fresh SLL 0x3 by 2 then returns 0x0000000C.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously during SHIFT and during DONE.
  - Required: outputs go to reset values without waiting for a clock edge.
  - After release, the next request completes normally.
